// File: rtl/age_select_arbiter.sv
// N-way issue select: oldest-first (wrap-aware age tag) or round-robin pick, held in a
// one-entry valid/ready output register, with a busy mask that blocks re-issue of granted lanes.
module age_select_arbiter #(
    parameter int  NUM_REQ = 8,
    parameter int  TAG_W   = 5,
    parameter int  MODE    = 0,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       i_req_ready,
    input  logic [NUM_REQ*TAG_W-1:0] i_req_tag,
    input  logic                     i_flush,
    output logic                     o_grant_valid,
    output logic [IDX_W-1:0]         o_grant_idx,
    output logic [TAG_W-1:0]         o_grant_tag,
    input  logic                     i_grant_ready,
    output logic [NUM_REQ-1:0]       o_busy_mask
);
    localparam int LEVELS = $clog2(NUM_REQ);
    localparam int PAD    = 1 << LEVELS;
    localparam int LOW_W  = TAG_W - 1;

    logic               r_valid;
    logic [IDX_W-1:0]   r_idx;
    logic [TAG_W-1:0]   r_tag;
    logic [NUM_REQ-1:0] r_busy;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic [NUM_REQ-1:0] w_held;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_ge_ptr;
    logic [NUM_REQ-1:0] w_rr_hi;
    logic [NUM_REQ-1:0] w_cand;
    logic               w_acc;
    logic               w_load_ok;
    logic               w_any;
    logic [IDX_W-1:0]   w_win_idx;
    logic [IDX_W-1:0]   w_ptr_next;
    logic [TAG_W-1:0]   w_win_tag;

    // a older than b: same wrap half compares ring index directly, otherwise inverted
    function automatic logic f_older(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
        if (a[TAG_W-1] == b[TAG_W-1])
            return a[LOW_W-1:0] < b[LOW_W-1:0];
        return a[LOW_W-1:0] > b[LOW_W-1:0];
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign w_held[i]   = r_valid & (r_idx == IDX_W'(i));
        assign w_elig[i]   = i_req_ready[i] & ~r_busy[i] & ~w_held[i];
        assign w_ge_ptr[i] = (IDX_W'(i) >= r_rr_ptr);
    end

    // Round-robin reuses the tree as a lowest-index finder over the rotated candidate set
    assign w_rr_hi = w_elig & w_ge_ptr;
    assign w_cand  = (MODE == 1) ? ((|w_rr_hi) ? w_rr_hi : w_elig) : w_elig;

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int NODES = PAD >> l;
        logic [NODES-1:0]            v;
        logic [NODES-1:0][IDX_W-1:0] ix;
        logic [NODES-1:0][TAG_W-1:0] tg;
        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < PAD; j++) begin : g_in
                if (j < NUM_REQ) begin : g_real
                    assign v[j]  = w_cand[j];
                    assign ix[j] = IDX_W'(j);
                    assign tg[j] = i_req_tag[j*TAG_W +: TAG_W];
                end else begin : g_pad
                    assign v[j]  = 1'b0;
                    assign ix[j] = IDX_W'(j);
                    assign tg[j] = '0;
                end
            end
        end else begin : g_cmp
            for (genvar j = 0; j < NODES; j++) begin : g_node
                logic w_take_r;
                // left holds lower lanes, so it keeps ties
                assign w_take_r = g_lvl[l-1].v[2*j+1] &
                                  (~g_lvl[l-1].v[2*j] |
                                   ((MODE == 0) & f_older(g_lvl[l-1].tg[2*j+1], g_lvl[l-1].tg[2*j])));
                assign v[j]  = g_lvl[l-1].v[2*j] | g_lvl[l-1].v[2*j+1];
                assign ix[j] = w_take_r ? g_lvl[l-1].ix[2*j+1] : g_lvl[l-1].ix[2*j];
                assign tg[j] = w_take_r ? g_lvl[l-1].tg[2*j+1] : g_lvl[l-1].tg[2*j];
            end
        end
    end

    assign w_any     = g_lvl[LEVELS].v[0];
    assign w_win_idx = g_lvl[LEVELS].ix[0];
    assign w_win_tag = g_lvl[LEVELS].tg[0];

    assign w_acc      = r_valid & i_grant_ready & ~i_flush;
    assign w_load_ok  = ~r_valid | i_grant_ready;
    assign w_ptr_next = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_tag    <= '0;
            r_busy   <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
                r_busy  <= '0;
            end else begin
                // a lane whose ready dropped clears even if accepted this cycle
                r_busy <= (r_busy | ({NUM_REQ{w_acc}} & w_held)) & i_req_ready;
                if (w_load_ok) begin
                    r_valid <= w_any;
                    if (w_any) begin
                        r_idx <= w_win_idx;
                        r_tag <= w_win_tag;
                    end
                end
            end
            if (w_acc)
                r_rr_ptr <= w_ptr_next;
        end
    end

    assign o_grant_valid = r_valid;
    assign o_grant_idx   = r_idx;
    assign o_grant_tag   = r_tag;
    assign o_busy_mask   = r_busy;

endmodule

// File: tb/tb_age_select_arbiter.sv
// Bench for age_select_arbiter: both pick modes side by side, directed cases then random
// traffic, each compared against an age/queue-level reference model.
module tb_age_select_arbiter;
    localparam int N  = 8;
    localparam int TW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    rdy;
    logic [N*TW-1:0] tagv;
    logic            fl;
    logic            gr;
    logic            v0, v1;
    logic [2:0]      ix0, ix1;
    logic [TW-1:0]   tg0, tg1;
    logic [N-1:0]    bm0, bm1;

    int tg[N];
    int head;
    int n_chk = 0;
    int n_err = 0;

    bit m_valid[2];
    int m_idx[2];
    int m_tag[2];
    int m_ptr[2];
    bit m_busy[2][N];
    int m_acc_lane[2];

    always #5 clk = ~clk;

    age_select_arbiter #(.NUM_REQ(N), .TAG_W(TW), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .i_req_ready(rdy), .i_req_tag(tagv), .i_flush(fl),
        .o_grant_valid(v0), .o_grant_idx(ix0), .o_grant_tag(tg0),
        .i_grant_ready(gr), .o_busy_mask(bm0)
    );

    age_select_arbiter #(.NUM_REQ(N), .TAG_W(TW), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .i_req_ready(rdy), .i_req_tag(tagv), .i_flush(fl),
        .o_grant_valid(v1), .o_grant_idx(ix1), .o_grant_tag(tg1),
        .i_grant_ready(gr), .o_busy_mask(bm1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // age = distance from the queue head around the tag ring; smaller is older
    function automatic int age(input int t);
        return (t - head) & 31;
    endfunction

    function automatic logic [N-1:0] busy_vec(input int m);
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) b[i] = m_busy[m][i];
        return b;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0; m_idx[m] = 0; m_tag[m] = 0; m_ptr[m] = 0; m_acc_lane[m] = -1;
            for (int i = 0; i < N; i++) m_busy[m][i] = 0;
        end
    endtask

    task automatic model_step(input int m);
        bit elig[N];
        int w;
        bit acc;
        w = -1;
        for (int i = 0; i < N; i++)
            elig[i] = rdy[i] && !m_busy[m][i] && !(m_valid[m] && m_idx[m] == i);
        if (m == 0) begin
            for (int i = 0; i < N; i++)
                if (elig[i] && (w < 0 || age(tg[i]) < age(tg[w]))) w = i;
        end else begin
            for (int k = 0; k < N; k++)
                if (w < 0 && elig[(m_ptr[m] + k) % N]) w = (m_ptr[m] + k) % N;
        end
        acc = m_valid[m] && gr && !fl;
        m_acc_lane[m] = acc ? m_idx[m] : -1;
        if (acc) m_ptr[m] = (m_idx[m] + 1) % N;
        if (fl) begin
            m_valid[m] = 0;
            for (int i = 0; i < N; i++) m_busy[m][i] = 0;
        end else begin
            for (int i = 0; i < N; i++)
                m_busy[m][i] = (m_busy[m][i] || (acc && m_idx[m] == i)) && rdy[i];
            if (!m_valid[m] || gr) begin
                if (w >= 0) begin
                    m_valid[m] = 1; m_idx[m] = w; m_tag[m] = tg[w] & 31;
                end else begin
                    m_valid[m] = 0;
                end
            end
        end
    endtask

    task automatic check_dut();
        chk("m0 valid", v0, m_valid[0]);
        if (m_valid[0]) begin
            chk("m0 idx", ix0, m_idx[0]);
            chk("m0 tag", tg0, m_tag[0]);
        end
        chk("m0 busy", bm0, busy_vec(0));
        chk("m1 valid", v1, m_valid[1]);
        if (m_valid[1]) begin
            chk("m1 idx", ix1, m_idx[1]);
            chk("m1 tag", tg1, m_tag[1]);
        end
        chk("m1 busy", bm1, busy_vec(1));
    endtask

    task automatic tick();
        for (int i = 0; i < N; i++) tagv[i*TW +: TW] = TW'(tg[i]);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_dut();
        @(negedge clk);
    endtask

    task automatic async_rst();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst valid0", v0, 0);
        chk("arst busy0", bm0, 0);
        chk("arst idx0", ix0, 0);
        chk("arst valid1", v1, 0);
        chk("arst busy1", bm1, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rdy = '0; fl = 0; gr = 0; head = 0; tagv = '0;
        for (int i = 0; i < N; i++) tg[i] = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst valid", v0, 0);
        chk("rst idx", ix0, 0);
        chk("rst tag", tg0, 0);
        chk("rst busy", bm0, 0);
        rst = 1'b0;

        // oldest of two ready lanes, then the other one back-to-back
        tg[2] = 5'h03; tg[5] = 5'h01; rdy = 8'h24; gr = 1;
        tick();
        chk("t1 idx", ix0, 5);
        chk("t1 tag", tg0, 5'h01);
        tick();
        chk("t1 busy5", bm0[5], 1);
        chk("t1 idx2", ix0, 2);
        rdy = '0;
        tick(); tick();

        // wrap bit differs: 0E is older than 10
        head = 5'h0E; tg[0] = 5'h10; tg[1] = 5'h0E; rdy = 8'h03;
        tick();
        chk("t2 idx", ix0, 1);
        chk("t2 tag", tg0, 5'h0E);
        rdy = '0;
        tick(); tick();

        // stalled grant is not displaced by an older arrival
        head = 0; tg[1] = 5; rdy = 8'h02; gr = 0;
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin rdy[7] = 1; tg[7] = 2; end
            tick();
            chk("t3 hold idx", ix0, 1);
            chk("t3 hold tag", tg0, 5);
        end
        gr = 1;
        tick();
        chk("t3 next idx", ix0, 7);
        chk("t3 next tag", tg0, 2);
        rdy = '0;
        tick(); tick();

        // round-robin sweep with the queue dropping each lane for a cycle after accept
        async_rst();
        for (int i = 0; i < N; i++) tg[i] = head;
        rdy = 8'hFF; gr = 1;
        for (int k = 0; k <= N; k++) begin
            tick();
            chk("t4 rr idx", ix1, k % N);
            rdy = 8'hFF;
            if (m_acc_lane[1] >= 0) rdy[m_acc_lane[1]] = 1'b0;
        end
        rdy = '0;
        tick(); tick();

        // flush beats accept and clears the busy mask
        tg[2] = 1; tg[3] = 2; tg[4] = 3; rdy = 8'h1C; gr = 1;
        tick(); tick(); tick();
        chk("t5 pre valid", v0, 1);
        chk("t5 pre busy", bm0, 8'h0C);
        fl = 1;
        tick();
        chk("t5 flush valid", v0, 0);
        chk("t5 flush busy", bm0, 8'h00);
        fl = 0; rdy = '0;
        tick();

        // async reset while a grant is held
        tg[5] = 1; tg[6] = 2; rdy = 8'h60; gr = 1;
        tick(); tick();
        chk("t6 pre valid", v0, 1);
        async_rst();
        tick();

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) head = $urandom_range(31);
            for (int i = 0; i < N; i++) tg[i] = (head + $urandom_range(15)) & 31;
            for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) rdy[i] = ~rdy[i];
            gr = ($urandom_range(3) != 0);
            fl = ($urandom_range(31) == 0);
            if ($urandom_range(199) == 0) async_rst();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
